// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
package multiplier_pkg;

  localparam int DEFAULT_WORD_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // Ceiling log2 for elaboration-time width calculations (value >= 1).
  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/multiplier_control_counter.sv
// Loadable down counter; terminal flags the last iteration (count == 1).
module iteration_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_terminal
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; the counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_terminal = (r_count == WIDTH'(1));

endmodule

// File: rtl/multiplier_control.sv
// Moore sequencer for an external shift-and-add multiplier datapath.
//
// state | meaning
// IDLE  | waiting for start, ready high
// LOAD  | parallel-load operands, clear accumulator
// CALC  | WORD_LENGTH shift cycles, accumulate when multiplier LSB is set
// DONE  | one-cycle done pulse, product valid in accumulator
module multiplier_control
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int COUNT_WIDTH = CLOG2(WORD_LENGTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic multiplierLsb,
  output logic loadOperands,
  output logic shiftOperands,
  output logic accClear,
  output logic accEnable,
  output logic ready,
  output logic busy,
  output logic done
);

  state_e r_state;
  state_e w_next;
  logic   w_terminal;

  // Iteration count: loaded in LOAD, stepped down through CALC.
  iteration_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_iteration_counter (
    .clk         (clk),
    .rst_n       (reset),
    .i_load      (r_state == LOAD),
    .i_load_value(COUNT_WIDTH'(WORD_LENGTH)),
    .i_dec       (r_state == CALC),
    .o_terminal  (w_terminal)
  );

  // Next-state decode; abort only cancels LOAD/CALC, never a finished product.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (start && !abort) ? LOAD : IDLE;
      LOAD:    w_next = abort ? IDLE : CALC;
      CALC:    begin
        if (abort)           w_next = IDLE;
        else if (w_terminal) w_next = DONE;
        else                 w_next = CALC;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  assign loadOperands  = (r_state == LOAD);
  assign accClear      = (r_state == LOAD);
  assign shiftOperands = (r_state == CALC);
  // Only output that looks at an input directly.
  assign accEnable     = (r_state == CALC) && multiplierLsb;
  assign ready         = (r_state == IDLE);
  assign busy          = (r_state == LOAD) || (r_state == CALC);
  assign done          = (r_state == DONE);

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control with a cycle-position reference model and a
// behavioural shift-and-add datapath driven by the DUT strobes.
module tb_multiplier_control;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset, start, abort, multiplierLsb;
  logic loadOperands, shiftOperands, accClear, accEnable, ready, busy, done;

  multiplier_control #(.WORD_LENGTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .multiplierLsb(multiplierLsb),
    .loadOperands (loadOperands),
    .shiftOperands(shiftOperands),
    .accClear     (accClear),
    .accEnable    (accEnable),
    .ready        (ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 = no operation, otherwise cycles since the op was accepted
  // (1 = load cycle, 2..W+1 = shift cycles, W+2 = done cycle).
  int m_op = 0;

  // External datapath model.
  logic [2*W-1:0] d_mcand = '0;
  logic [2*W-1:0] d_acc   = '0;
  logic [W-1:0]   d_mplier = '0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic c_load, c_shift, c_clr, c_en;

  wire [6:0] w_out = {ready, busy, loadOperands, shiftOperands, accClear, accEnable, done};

  function automatic logic [6:0] exp_vec();
    logic ld, sh, dn;
    ld = (m_op == 1);
    sh = (m_op >= 2) && (m_op <= W + 1);
    dn = (m_op == W + 2);
    return {m_op == 0, ld | sh, ld, sh, ld, sh & multiplierLsb, dn};
  endfunction

  // Advance one clock: capture strobes, update models at the edge, return at negedge.
  task automatic tick();
    c_load  = loadOperands;
    c_shift = shiftOperands;
    c_clr   = accClear;
    c_en    = accEnable;
    @(posedge clk);
    if (!reset) begin
      m_op = 0;
    end else if (m_op == 0) begin
      m_op = (start && !abort) ? 1 : 0;
    end else if (m_op == W + 2) begin
      m_op = 0;
    end else if (abort) begin
      m_op = 0;
    end else begin
      m_op = m_op + 1;
    end
    if (c_clr) d_acc = '0;
    else if (c_en) d_acc = d_acc + d_mcand;
    if (c_load) begin
      d_mcand  = {{W{1'b0}}, op_a};
      d_mplier = op_b;
    end else if (c_shift) begin
      d_mcand  = d_mcand << 1;
      d_mplier = d_mplier >> 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; multiplierLsb = 1'b0;
    #3;
    total++;
    if (w_out !== 7'b1000000) begin
      bad++; $display("FAIL reset_async got=%b exp=%b", w_out, 7'b1000000);
    end
    tick();
    start = 1'b1; multiplierLsb = 1'b1;
    #1;
    total++;
    if (w_out !== 7'b1000000) begin
      bad++; $display("FAIL reset_hold got=%b exp=%b", w_out, 7'b1000000);
    end
    tick();
    reset = 1'b1; start = 1'b0; multiplierLsb = 1'b0;
    #1;
    total++;
    if (w_out !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%b exp=%b", w_out, exp_vec());
    end
  endtask

  task automatic test_single_op();
    logic [7:0] pat;
    int done_cyc;
    pat = 8'hA5;
    done_cyc = -1;
    op_a = 8'h0F; op_b = 8'hA5;
    abort = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      multiplierLsb = d_mplier[0];
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL single_op cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (c >= 2 && c <= 9) begin
        total++;
        if (accEnable !== pat[c-2]) begin
          bad++; $display("FAIL acc_pattern cyc=%0d got=%b exp=%b", c, accEnable, pat[c-2]);
        end
      end
      if (done === 1'b1) begin
        done_cyc = c;
        total++;
        if (d_acc !== 16'h09AB) begin
          bad++; $display("FAIL product got=%h exp=%h", d_acc, 16'h09AB);
        end
      end
      if (c == 11) begin
        total++;
        if (ready !== 1'b1) begin
          bad++; $display("FAIL ready_after_done got=%b exp=1", ready);
        end
      end
      tick();
    end
    total++;
    if (done_cyc != W + 2) begin
      bad++; $display("FAIL done_latency got=%0d exp=%0d", done_cyc, W + 2);
    end
  endtask

  task automatic test_ignore_start();
    int ndone, dcyc;
    ndone = 0; dcyc = -1;
    abort = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      start = (c == 0) || (c == 4) || (c == 10);
      multiplierLsb = d_mplier[0];
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL ignore_start cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (done === 1'b1) begin ndone++; dcyc = c; end
      tick();
    end
    start = 1'b0;
    total++;
    if (ndone != 1 || dcyc != 10) begin
      bad++; $display("FAIL ignore_start_done count=%0d cyc=%0d exp count=1 cyc=10", ndone, dcyc);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      abort = (c == 5);
      multiplierLsb = $urandom_range(0, 1);
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL abort cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (c == 6) begin
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
          bad++; $display("FAIL abort_idle ready=%b busy=%b exp ready=1 busy=0", ready, busy);
        end
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    abort = 1'b0;
    total++;
    if (ndone != 0) begin
      bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone);
    end
    ndone = 0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      multiplierLsb = $urandom_range(0, 1);
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL abort_restart cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL abort_restart_done got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_start_abort_idle();
    for (int c = 0; c < 4; c++) begin
      start = 1'b1; abort = 1'b1; multiplierLsb = 1'b1;
      #1;
      total++;
      if (loadOperands !== 1'b0 || ready !== 1'b1) begin
        bad++; $display("FAIL start_abort_idle cyc=%0d load=%b ready=%b exp load=0 ready=1",
                        c, loadOperands, ready);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    for (int c = 0; c <= 4; c++) begin
      start = (c == 0);
      multiplierLsb = 1'b1;
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (c < 4) tick();
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (w_out !== 7'b1000000) begin
      bad++; $display("FAIL reset_mid_async got=%b exp=%b", w_out, 7'b1000000);
    end
    tick();
    reset = 1'b1; start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      multiplierLsb = $urandom_range(0, 1);
      #1;
      if (done === 1'b1) ndone++;
      tick();
    end
    total++;
    if (ndone != 0 || m_op != 0) begin
      bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", ndone);
    end
    start = 1'b1;
    #1;
    tick();
    start = 1'b0;
    #1;
    total++;
    if (loadOperands !== 1'b1) begin
      bad++; $display("FAIL first_start_after_reset got=%b exp=1", loadOperands);
    end
    for (int c = 0; c < W + 2; c++) tick();
  endtask

  task automatic test_back_to_back();
    int ndone, last_done, gap;
    ndone = 0; last_done = -1; gap = -1;
    start = 1'b1; abort = 1'b0;
    for (int c = 0; c < 36; c++) begin
      multiplierLsb = $urandom_range(0, 1);
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      if (done === 1'b1) begin ndone++; last_done = c; end
      if (loadOperands === 1'b1 && last_done >= 0 && gap < 0) gap = c - last_done;
      tick();
    end
    start = 1'b0;
    total++;
    if (ndone != 3 || gap != 2) begin
      bad++; $display("FAIL back_to_back_count dones=%0d gap=%0d exp dones=3 gap=2", ndone, gap);
    end
    for (int c = 0; c < W + 3; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 15) == 0);
      multiplierLsb = $urandom_range(0, 1);
      #1;
      total++;
      if (w_out !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, w_out, exp_vec());
      end
      total++;
      if (loadOperands === 1'b1 && shiftOperands === 1'b1) begin
        bad++; $display("FAIL load_shift_overlap cyc=%0d got=11 exp=not both", c);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_ignore_start();
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter COUNT_WIDTH, default CLOG2(WORD_LENGTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one multiplication; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-007 SHALL have port multiplierLsb  input  1  current LSB of the multiplier (right-shifting) register.
REQ-008 SHALL have port loadOperands  output  1  parallel-load strobe to the multiplicand and multiplier registers.
REQ-009 SHALL have port shiftOperands  output  1  shift strobe: multiplicand left, multiplier right.
REQ-010 SHALL have port accClear  output  1  synchronous clear of the product accumulator.
REQ-011 SHALL have port accEnable  output  1  accumulator adds the multiplicand parallel output this cycle.
REQ-012 SHALL have port ready  output  1  high only in IDLE.
REQ-013 SHALL have port busy  output  1  high in LOAD and CALC.
REQ-014 SHALL have port done  output  1  one-cycle pulse; product valid in the accumulator.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, LOAD, CALC, DONE.
REQ-016 IDLE: start=1 and abort=0 -> LOAD next cycle; otherwise stay in IDLE.
REQ-017 LOAD: loadOperands=1, accClear=1 for exactly one cycle; iteration counter set to WORD_LENGTH; -> CALC.
REQ-018 CALC: shiftOperands=1 every cycle; accEnable=multiplierLsb (the only combinational output path); counter decrements by 1 each cycle.
REQ-019 CALC lasts exactly WORD_LENGTH cycles; when the counter equals 1, the next state is DONE.
REQ-020 DONE: done=1 for one cycle, all strobes 0; -> IDLE.
REQ-021 Latency: if start is sampled at edge 0, loadOperands is high during cycle 1, shiftOperands during cycles 2..WORD_LENGTH+1, and done during cycle WORD_LENGTH+2.
REQ-022 start SHALL be ignored outside IDLE; no queuing; start held high in DONE has no effect until IDLE.
REQ-023 start held continuously high SHALL start back-to-back operations, with one IDLE cycle between done and the next LOAD.
REQ-024 abort=1 in LOAD or CALC -> IDLE next cycle with no done pulse; abort SHALL have no effect in DONE.
REQ-025 start and abort both high in IDLE: abort wins, stay in IDLE.
REQ-026 loadOperands and shiftOperands SHALL never be high in the same cycle.
REQ-027 accEnable SHALL be 0 in every state other than CALC.
REQ-028 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-029 reset=0 SHALL force IDLE asynchronously, clear the counter, set ready=1, and set all other outputs to 0.
REQ-030 reset asserted in mid-operation SHALL discard the operation; no done pulse follows after reset deasserts.
REQ-031 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-032 A shared package multiplier_pkg SHALL hold the state enum (IDLE, LOAD, CALC, DONE), the CLOG2 function and the default WORD_LENGTH constant.
REQ-033 The iteration counter SHALL be a sub-module, iteration_counter: a loadable down counter with a terminal-count output.
REQ-034 The block SHALL contain no arithmetic datapath; the shift registers and accumulator remain external.

Verification (WORD_LENGTH=8)
REQ-035 Start pulse at cycle 0 -> loadOperands in cycle 1, shiftOperands in cycles 2-9, done in cycle 10, ready back high in cycle 11.
REQ-036 multiplierLsb driven as the LSB sequence of 0xA5 -> accEnable pattern 1,0,1,0,0,1,0,1 over cycles 2-9; external product 0x0F x 0xA5 = 0x09AB.
REQ-037 start pulsed in cycles 4 and 10 -> ignored, exactly one done pulse at cycle 10.
REQ-038 abort in cycle 5 -> IDLE in cycle 6, no done, ready=1; next start accepted normally.
REQ-039 reset asserted asynchronously mid-CALC (between edges) -> all outputs at reset values immediately; no done pulse within 20 cycles.
REQ-040 start and abort high together in IDLE -> no loadOperands, ready stays 1.
